// File: rtl/pc_trace_unit_if.sv
// Trace drain port of pc_trace_unit: show-ahead head word, occupancy and
// ready/valid handshake between the monitor (master) and a host/UART (slave).
interface pc_trace_unit_if #(
  parameter int PC_W  = 16,
  parameter int DEPTH = 16
);
  logic [PC_W-1:0]         trace_data;
  logic                    trace_valid;
  logic                    trace_ready;
  logic [$clog2(DEPTH):0]  trace_count;

  modport master (
    output trace_data,
    output trace_valid,
    output trace_count,
    input  trace_ready
  );

  modport slave (
    input  trace_data,
    input  trace_valid,
    input  trace_count,
    output trace_ready
  );
endinterface

// File: rtl/pc_trace_unit.sv
// PC debug monitor: saturating cycle counter, running PC checksum, sticky
// breakpoints and a cycle-windowed show-ahead trace FIFO drained over ready/valid.
module pc_trace_unit #(
  parameter int PC_W   = 16,
  parameter int CYC_W  = 32,
  parameter int DEPTH  = 16,
  parameter int NUM_BP = 4
) (
  input  logic                     cpu_clk,
  input  logic                     rst,
  input  logic [PC_W-1:0]          pc_in,
  input  logic                     pc_valid,
  input  logic [CYC_W-1:0]         win_start,
  input  logic [CYC_W-1:0]         win_end,
  input  logic [NUM_BP*PC_W-1:0]   bp_addr,
  input  logic [NUM_BP-1:0]        bp_en,
  input  logic                     halt_clr,
  pc_trace_unit_if.master          trace,
  output logic                     overflow,
  output logic [PC_W-1:0]          cksm,
  output logic [CYC_W-1:0]         cycles,
  output logic [1:0]               state,
  output logic [NUM_BP-1:0]        bp_hit,
  output logic                     halt_req
);

  localparam int AW    = $clog2(DEPTH);
  localparam int CNT_W = AW + 1;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_CAPTURE = 2'd1,
    ST_DONE    = 2'd2
  } state_t;

  function automatic logic [CYC_W-1:0] sat_inc(input logic [CYC_W-1:0] v);
    if (v == {CYC_W{1'b1}}) begin
      return v;
    end else begin
      return v + {{(CYC_W-1){1'b0}}, 1'b1};
    end
  endfunction

  state_t               r_state;
  logic [CYC_W-1:0]     r_cycles;
  logic [PC_W-1:0]      r_cksm;
  logic [NUM_BP-1:0]    r_bp_hit;
  logic                 r_halt_req;
  logic [PC_W-1:0]      r_mem [DEPTH];
  logic [AW-1:0]        r_rd_ptr;
  logic [AW-1:0]        r_wr_ptr;
  logic [CNT_W-1:0]     r_count;
  logic                 r_valid;
  logic                 r_overflow;
  logic [PC_W-1:0]      r_trace_data;

  logic                 w_capture;
  logic                 w_full;
  logic                 w_push;
  logic                 w_pop;
  logic                 w_push_ok;
  logic                 w_drop;
  logic [AW-1:0]        w_rd_next;
  logic [AW-1:0]        w_wr_next;
  logic [CNT_W-1:0]     w_count_next;
  logic [PC_W-1:0]      w_head_next;
  logic [NUM_BP-1:0]    w_bp_match;
  logic [NUM_BP-1:0]    w_bp_next;

  // FIFO handshake decode: a pop on a full FIFO makes room for a same-edge push
  always_comb begin
    w_capture = (r_state == ST_CAPTURE);
    w_full    = (r_count == CNT_W'(DEPTH));
    w_push    = w_capture && pc_valid;
    w_pop     = r_valid && trace.trace_ready;
    w_push_ok = w_push && (!w_full || w_pop);
    w_drop    = w_push && w_full && !w_pop;
    w_rd_next = w_pop     ? (r_rd_ptr + AW'(1)) : r_rd_ptr;
    w_wr_next = w_push_ok ? (r_wr_ptr + AW'(1)) : r_wr_ptr;
  end

  // Next occupancy and next show-ahead head word
  always_comb begin
    w_count_next = r_count;
    case ({w_push_ok, w_pop})
      2'b10:   w_count_next = r_count + CNT_W'(1);
      2'b01:   w_count_next = r_count - CNT_W'(1);
      default: w_count_next = r_count;
    endcase
    // The new head slot may be the one being written this very edge
    if (w_count_next == CNT_W'(0)) begin
      w_head_next = r_trace_data;
    end else if (w_push_ok && (r_wr_ptr == w_rd_next)) begin
      w_head_next = pc_in;
    end else begin
      w_head_next = r_mem[w_rd_next];
    end
  end

  // Breakpoint compare; halt_clr wins over a same-cycle match
  always_comb begin
    w_bp_match = '0;
    for (int i = 0; i < NUM_BP; i++) begin
      w_bp_match[i] = pc_valid && bp_en[i] && (pc_in == bp_addr[i*PC_W +: PC_W]);
    end
    if (halt_clr) begin
      w_bp_next = '0;
    end else begin
      w_bp_next = r_bp_hit | w_bp_match;
    end
  end

  // Window FSM, compared against the pre-increment cycle count
  always_ff @(posedge cpu_clk) begin
    if (rst) begin
      r_state <= ST_IDLE;
    end else begin
      case (r_state)
        ST_IDLE: begin
          if (win_end <= win_start) begin
            r_state <= ST_DONE;
          end else if (r_cycles >= win_start) begin
            r_state <= ST_CAPTURE;
          end else begin
            r_state <= ST_IDLE;
          end
        end
        ST_CAPTURE: begin
          if (r_cycles >= win_end) begin
            r_state <= ST_DONE;
          end else begin
            r_state <= ST_CAPTURE;
          end
        end
        ST_DONE:  r_state <= ST_DONE;
        default:  r_state <= ST_IDLE;
      endcase
    end
  end

  // Counter, checksum and breakpoint flags run in every FSM state
  always_ff @(posedge cpu_clk) begin
    if (rst) begin
      r_cycles   <= '0;
      r_cksm     <= '0;
      r_bp_hit   <= '0;
      r_halt_req <= 1'b0;
    end else begin
      r_cycles   <= sat_inc(r_cycles);
      r_cksm     <= pc_valid ? (r_cksm + pc_in) : r_cksm;
      r_bp_hit   <= w_bp_next;
      r_halt_req <= |w_bp_next;
    end
  end

  // Trace storage; contents need no reset since pointers/count gate visibility
  always_ff @(posedge cpu_clk) begin
    if (w_push_ok && !rst) begin
      r_mem[r_wr_ptr] <= pc_in;
    end
  end

  // FIFO pointers, occupancy, registered head and sticky overflow
  always_ff @(posedge cpu_clk) begin
    if (rst) begin
      r_rd_ptr     <= '0;
      r_wr_ptr     <= '0;
      r_count      <= '0;
      r_valid      <= 1'b0;
      r_overflow   <= 1'b0;
      r_trace_data <= '0;
    end else begin
      r_rd_ptr     <= w_rd_next;
      r_wr_ptr     <= w_wr_next;
      r_count      <= w_count_next;
      r_valid      <= (w_count_next != CNT_W'(0));
      r_overflow   <= r_overflow || w_drop;
      r_trace_data <= w_head_next;
    end
  end

  assign trace.trace_data  = r_trace_data;
  assign trace.trace_valid = r_valid;
  assign trace.trace_count = r_count;
  assign overflow          = r_overflow;
  assign cksm              = r_cksm;
  assign cycles            = r_cycles;
  assign state             = r_state;
  assign bp_hit            = r_bp_hit;
  assign halt_req          = r_halt_req;

endmodule

// File: doc/pc_trace_unit.md
# pc_trace_unit

Synthesizable debug monitor that samples the CPU program counter every `cpu_clk` cycle and provides a free-running cycle counter, a running PC checksum, and a cycle-windowed trace FIFO. It also has up to `NUM_BP` PC breakpoints that raise a sticky halt request. It sits beside the datapath, taps `PC` and the fetch strobe, and drains trace words over a ready/valid port to a host or debug UART. This lets hardware runs be compared against simulation cksm/cycle stop points.

## Interface
- `PC_W`, 16, PC and checksum width
- `CYC_W`, 32, cycle counter width
- `DEPTH`, 16, trace FIFO entries; power of two, ≥2
- `NUM_BP`, 4, breakpoint comparators; ≥1

- `cpu_clk` in 1: sole clock, rising edge
- `rst` in 1: synchronous, active-high reset
- `pc_in` in `PC_W`: current datapath PC
- `pc_valid` in 1: `pc_in` is meaningful this cycle
- `win_start` in `CYC_W`: capture window opens when `cycles > win_start`
- `win_end` in `CYC_W`: capture window closes after `cycles == win_end`
- `bp_addr` in `NUM_BP*PC_W`: breakpoint i at bits [i*PC_W +: PC_W]
- `bp_en` in `NUM_BP`: per-breakpoint enable
- `halt_clr` in 1: clears `halt_req` and `bp_hit`
- `trace_ready` in 1: consumer accepts a trace word
- `trace_data` out `PC_W`: FIFO head (show-ahead)
- `trace_valid` out 1: FIFO non-empty
- `trace_count` out `$clog2(DEPTH)+1`: current occupancy
- `overflow` out 1: sticky; a push was dropped because the FIFO was full
- `cksm` out `PC_W`: running PC sum modulo 2^`PC_W`
- `cycles` out `CYC_W`: cycles since reset, saturating
- `state` out 2: 0 IDLE, 1 CAPTURE, 2 DONE
- `bp_hit` out `NUM_BP`: sticky per-breakpoint match flags
- `halt_req` out 1: sticky OR of `bp_hit`

## Operation
- **Reset:** while `rst`=1 at an edge, all outputs go to 0: `cycles`, `cksm`, `trace_count`, `trace_valid`, `overflow`, `bp_hit`, `halt_req`, `trace_data` = 0, and `state` = IDLE. FIFO pointers are cleared. Asserting reset mid-capture discards all FIFO contents.
- **Cycle counter:** `cycles` increments by 1 on every non-reset edge. It saturates at all-ones and does not wrap.
- **Checksum:** on each edge with `pc_valid`=1, `cksm` ← `cksm + pc_in`. Carry out of `PC_W` bits is discarded.
- **Window FSM.** All comparisons use the pre-increment `cycles`.
  - IDLE → CAPTURE when `cycles >= win_start`. Samples are taken on the following edges, so they cover `cycles` values in (`win_start`, `win_end`].
  - CAPTURE → DONE when `cycles == win_end`. That edge still pushes.
  - DONE holds until reset.
  - If `win_end <= win_start`, the FSM goes IDLE → DONE directly and captures nothing.
- **Push:** a push occurs in CAPTURE when `pc_valid`=1. If the FIFO is full and no pop happens on the same edge, the word is dropped and `overflow` is set.
- **Pop:** a pop occurs when `trace_valid` and `trace_ready` are both 1.
- **Push and pop on the same edge:**
  - Both are accepted and `trace_count` is unchanged.
  - When the FIFO is full, the pop frees a slot, the push succeeds, and there is no overflow.
  - When the FIFO is empty, only the push takes effect; there is no fall-through.
- **Pointers:** read and write pointers wrap modulo `DEPTH`.
- **Breakpoints:** on each edge with `pc_valid`=1, every i with `bp_en[i]`=1 and `pc_in == bp_addr[i]` sets `bp_hit[i]`.
  - `halt_req` is registered as the OR of the next-state `bp_hit`.
  - `halt_clr` takes priority over a same-cycle match: hit flags are cleared and that match is lost.
- Breakpoints, checksum and counter run in every FSM state.

## Timing
- All outputs are registered; there are no combinational input-to-output paths.
- `cksm`, `bp_hit`, `halt_req`: visible 1 cycle after the sampling edge.
- Trace latency: a word pushed at edge N is on `trace_data` with `trace_valid`=1 from edge N onward, and can be popped at edge N+1.
- `trace_data` holds its value while `trace_valid`=1 and `trace_ready`=0.
- `trace_data` is don't-care when `trace_valid`=0.
- Throughput: 1 push and 1 pop per cycle.

## Test plan
- **Reset values:** hold `rst` 3 cycles with random inputs → all outputs 0 and `state`=IDLE. Release; after 5 edges `cycles`=5.
- **Checksum wrap:** `PC_W`=16, `pc_valid`=1, `pc_in`=0x8000 for 3 edges → `cksm`=0x8000 after edge 3. Then `pc_in`=0x0001 for 1 edge → 0x8001.
- **Window:** `win_start`=10, `win_end`=13, `pc_in`=`cycles` low bits.
  - Exactly 3 words (11, 12, 13) are captured.
  - `state` reaches DONE after the edge where `cycles`=13.
  - With `win_end`=10, nothing is captured.
- **Full/overflow:** `DEPTH`=4, `trace_ready`=0, 6-cycle window → `trace_count`=4, `overflow`=1, and the first 4 PCs are retained in order.
  - Repeat with `trace_ready`=1 on the cycle the FIFO is full → no overflow, `trace_count` stays 4.
- **Breakpoints:** `bp_addr[1]`=0x0150, `bp_en`=0b0010. Drive `pc_in`=0x0150 with `pc_valid`=1 → `bp_hit`=0b0010 and `halt_req`=1 the next cycle, sticky.
  - `halt_clr` pulsed while `pc_in`=0x0150 → both read 0.
- **Reset mid-capture:** assert `rst` with `trace_count`=3 in CAPTURE → next cycle `trace_count`=0, `trace_valid`=0, `state`=IDLE, `cycles`=0.
